// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline package: buffer-register payloads plus the hazard sequencer's
// state and action encodings.
package pipe_hazard_ctrl_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_src;
    } id_ex_ctrl_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_REDIRECT = 2'd2
    } hz_state_e;

    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_FREEZE   = 3'd1,
        ACT_BRANCH   = 3'd2,
        ACT_LOAD_USE = 3'd3,
        ACT_REFILL   = 3'd4
    } hz_act_e;

    // rd of a load in EX feeding an operand the ID instruction really reads; x0 never hazards
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       uses_rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // count register: sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// taken-branch redirects and data-memory wait freezes, with perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    localparam int               TMO_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
    localparam logic             TMO_EN     = (MEM_TIMEOUT > 0);
    localparam logic             REDIR_EN   = (REDIRECT_CYCLES > 0);
    localparam logic [2:0]       REDIR_LOAD = (REDIRECT_CYCLES > 0) ? 3'(REDIRECT_CYCLES - 1) : 3'd0;

    hz_state_e        state_r, state_nxt_s;
    hz_act_e          act_s;
    logic [2:0]       redir_cnt_r, redir_nxt_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_clr_s, tmo_inc_s, tmo_hit_s;
    logic             mem_timeout_r;
    logic             mem_stall_s, load_use_s;

    assign mem_stall_s = mem_req && !mem_ready;
    assign load_use_s  = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_uses_rs1,
                                         id_rs2, id_uses_rs2);
    assign tmo_hit_s   = tmo_inc_s && ((tmo_cnt_r + TMO_ONE) == TMO_LIMIT);

    // state, redirect countdown, wait timer and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= HZ_RUN;
            redir_cnt_r   <= 3'd0;
            tmo_cnt_r     <= {TMO_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            redir_cnt_r <= redir_nxt_s;
            if (tmo_clr_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (tmo_inc_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            mem_timeout_r <= mem_timeout_r || tmo_hit_s;
        end
    end

    // next state and the action taken this cycle; memory wait beats branch beats load-use
    always_comb begin
        state_nxt_s = HZ_RUN;
        redir_nxt_s = redir_cnt_r;
        act_s       = ACT_NONE;
        tmo_clr_s   = 1'b0;
        tmo_inc_s   = 1'b0;
        case (state_r)
            HZ_RUN: begin
                if (mem_stall_s) begin
                    act_s       = ACT_FREEZE;
                    state_nxt_s = HZ_MEM_WAIT;
                    tmo_clr_s   = 1'b1;
                end else if (ex_branch_taken) begin
                    act_s       = ACT_BRANCH;
                    state_nxt_s = REDIR_EN ? HZ_REDIRECT : HZ_RUN;
                    redir_nxt_s = REDIR_LOAD;
                end else if (load_use_s) begin
                    act_s       = ACT_LOAD_USE;
                    state_nxt_s = HZ_RUN;
                end else begin
                    act_s       = ACT_NONE;
                    state_nxt_s = HZ_RUN;
                end
            end
            HZ_MEM_WAIT: begin
                if (!mem_ready) begin
                    act_s       = ACT_FREEZE;
                    state_nxt_s = HZ_MEM_WAIT;
                    tmo_inc_s   = TMO_EN && (tmo_cnt_r != TMO_LIMIT);
                end else if (ex_branch_taken) begin
                    // the branch was frozen in EX for the whole wait and resolves now
                    act_s       = ACT_BRANCH;
                    state_nxt_s = REDIR_EN ? HZ_REDIRECT : HZ_RUN;
                    redir_nxt_s = REDIR_LOAD;
                end else begin
                    act_s       = ACT_NONE;
                    state_nxt_s = HZ_RUN;
                end
            end
            HZ_REDIRECT: begin
                if (mem_stall_s) begin
                    // PC already holds the target, so the leftover refill count is dropped
                    act_s       = ACT_FREEZE;
                    state_nxt_s = HZ_MEM_WAIT;
                    tmo_clr_s   = 1'b1;
                end else if (redir_cnt_r == 3'd0) begin
                    act_s       = ACT_REFILL;
                    state_nxt_s = HZ_RUN;
                end else begin
                    act_s       = ACT_REFILL;
                    state_nxt_s = HZ_REDIRECT;
                    redir_nxt_s = redir_cnt_r - 3'd1;
                end
            end
            default: begin
                act_s       = ACT_NONE;
                state_nxt_s = HZ_RUN;
            end
        endcase
    end

    // buffer-register controls decoded from the action; reset forces a safe bubble
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else begin
            case (act_s)
                ACT_FREEZE: begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_hold   = 1'b1;
                    mem_wb_bubble = 1'b1;
                end
                ACT_BRANCH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ACT_LOAD_USE: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
                ACT_REFILL: begin
                    if_id_flush = 1'b1;
                end
                ACT_NONE: begin
                    pc_write = 1'b1;
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (act_s == ACT_BRANCH),
        .count (flush_events)
    );

    assign ctrl_state  = state_r;
    assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipe_hazard_ctrl (REDIRECT_CYCLES=1, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic       ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic       ex_mem_hold, mem_wb_bubble, mem_timeout;
    logic [1:0] ctrl_state;
    logic [7:0] stall_cycles, flush_events;

    pipe_hazard_ctrl #(.REDIRECT_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
        .mem_wb_bubble(mem_wb_bubble), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble}
    localparam logic [6:0] DEF = 7'b111_0000;
    localparam logic [6:0] RST = 7'b000_1101;
    localparam logic [6:0] FRZ = 7'b000_0011;
    localparam logic [6:0] BRF = 7'b111_1100;
    localparam logic [6:0] RDR = 7'b111_1000;
    localparam logic [6:0] LUS = 7'b001_0100;
    localparam logic [1:0] R = 2'd0, W = 2'd1, D = 2'd2;

    typedef struct {
        logic [6:0] ctl;
        logic [1:0] st;
        int         stall;
        int         flush;
        logic       tmo;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // monitor: the control outputs are presented every cycle; compare at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [31:0] s_exp, f_exp;
            e = q.pop_front();
            s_exp = e.stall;
            f_exp = e.flush;
            chk("ctl", {25'd0, pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                        ex_mem_hold, mem_wb_bubble}, {25'd0, e.ctl});
            chk("state", {30'd0, ctrl_state}, {30'd0, e.st});
            chk("stall_cycles", {24'd0, stall_cycles}, s_exp);
            chk("flush_events", {24'd0, flush_events}, f_exp);
            chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.tmo});
        end
    end

    task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic br, input logic mreq, input logic mrdy,
                        input logic [6:0] ctl, input logic [1:0] st, input int s,
                        input int f, input logic t);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_uses_rs1 = u1;
        id_rs2 = rs2; id_uses_rs2 = u2; ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        e.ctl = ctl; e.st = st; e.stall = s; e.flush = f; e.tmo = t;
        q.push_back(e);
    endtask

    initial begin
        // reset values
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, R, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, R, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 0, 0, 0);
        // load-use: lw x5 then add x6,x5,x1; x0 target; rs2 path; unused operand; no load
        step(0, 1, 5, 5, 1, 1, 1, 0, 0, 0, LUS, R, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, DEF, R, 1, 0, 0);
        step(0, 1, 5, 5, 0, 5, 1, 0, 0, 0, LUS, R, 1, 0, 0);
        step(0, 1, 5, 5, 0, 6, 1, 0, 0, 0, DEF, R, 2, 0, 0);
        step(0, 0, 5, 5, 1, 0, 0, 0, 0, 0, DEF, R, 2, 0, 0);
        // taken branch, one refill cycle with a load-use pattern that must be ignored
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BRF, R, 2, 0, 0);
        step(0, 1, 5, 5, 1, 0, 0, 0, 0, 0, RDR, D, 2, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 2, 1, 0);
        // memory wait of 3 cycles, release on the 4th
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, R, 2, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 4, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, W, 5, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 5, 1, 0);
        // release and branch in the same wait cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, R, 5, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, BRF, W, 6, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RDR, D, 6, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 6, 2, 0);
        // memory wait during a redirect wins and drops the refill
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BRF, R, 6, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, D, 6, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, W, 7, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 7, 3, 0);
        // reset in the middle of a wait
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, R, 7, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 8, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST, R, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 0, 0, 0);
        // timeout after 4 wait cycles, sticky past release
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, R, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 4, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, W, 5, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, W, 6, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, R, 6, 0, 1);
        begin
            int n = 0;
            while (q.size() > 0 && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
